// File: rtl/tc_sram_rsp_adapter.sv
// Request/response adapter in front of a fixed-latency tc_sram port.
// Define TC_SRAM_RSP_CREDIT_BYPASS_EN to let a same-cycle pop free a read credit.
module tc_sram_rsp_adapter #(
  parameter int unsigned NumWords  = 1024,
  parameter int unsigned DataWidth = 64,
  parameter int unsigned ByteWidth = 8,
  parameter int unsigned Latency   = 1,
  parameter int unsigned RspDepth  = 2,
  parameter int unsigned AddrWidth =
    (NumWords > 1) ? $clog2(NumWords) : 1,
  parameter int unsigned BeWidth   =
    (DataWidth + ByteWidth - 1) / ByteWidth
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 req_i,
  output logic                 gnt_o,
  input  logic                 we_i,
  input  logic [AddrWidth-1:0] addr_i,
  input  logic [DataWidth-1:0] wdata_i,
  input  logic [BeWidth-1:0]   be_i,
  output logic                 rvalid_o,
  input  logic                 rready_i,
  output logic [DataWidth-1:0] rdata_o,
  output logic                 sram_req_o,
  output logic                 sram_we_o,
  output logic [AddrWidth-1:0] sram_addr_o,
  output logic [DataWidth-1:0] sram_wdata_o,
  output logic [BeWidth-1:0]   sram_be_o,
  input  logic [DataWidth-1:0] sram_rdata_i
);

  localparam int unsigned CntW = $clog2(RspDepth + 1);
  localparam int unsigned PtrW =
    (RspDepth > 1) ? $clog2(RspDepth) : 1;
  localparam int unsigned MkW  = (Latency > 0) ? Latency : 1;
  localparam logic [CntW-1:0] Depth = CntW'(RspDepth);
  localparam logic [PtrW-1:0] Last  = PtrW'(RspDepth - 1);

  if (Latency < 1) begin : g_lat_chk
    $error("tc_sram_rsp_adapter: Latency must be >= 1");
  end

  if (RspDepth < 1) begin : g_dep_chk
    $error("tc_sram_rsp_adapter: RspDepth must be >= 1");
  end

  logic [CntW-1:0]      credit_q, credit_d;
  logic [CntW-1:0]      occ_q, occ_d;
  logic [MkW-1:0]       mark_q, mark_d;
  logic [PtrW-1:0]      wptr_q, rptr_q;
  logic [DataWidth-1:0] mem_q [RspDepth];

  logic rd_ok;
  logic rd_fire;
  logic push;
  logic pop;

  function automatic logic [PtrW-1:0] nxt(
    input logic [PtrW-1:0] p
  );
    return (p == Last) ? '0 : p + PtrW'(1);
  endfunction

  assign rvalid_o = (occ_q != '0);
  assign rdata_o  = mem_q[rptr_q];
  assign pop      = rvalid_o && rready_i;
  assign push     = mark_q[MkW-1];

`ifdef TC_SRAM_RSP_CREDIT_BYPASS_EN
  // A pop implies credit_q >= 1, so the subtraction cannot wrap.
  assign rd_ok = (credit_q - CntW'(pop)) < Depth;
`else
  assign rd_ok = credit_q < Depth;
`endif

  assign gnt_o      = !rst_i && req_i && (we_i || rd_ok);
  assign sram_req_o = req_i && gnt_o;
  assign rd_fire    = sram_req_o && !we_i;

  assign sram_we_o    = we_i;
  assign sram_addr_o  = addr_i;
  assign sram_wdata_o = wdata_i;
  assign sram_be_o    = be_i;

  always_comb begin
    mark_d    = '0;
    mark_d[0] = rd_fire;
    for (int i = 1; i < int'(MkW); i++) begin
      mark_d[i] = mark_q[i-1];
    end
  end

  assign credit_d = credit_q + CntW'(rd_fire) - CntW'(pop);
  assign occ_d    = occ_q + CntW'(push) - CntW'(pop);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      credit_q <= '0;
      occ_q    <= '0;
      mark_q   <= '0;
      wptr_q   <= '0;
      rptr_q   <= '0;
      for (int i = 0; i < int'(RspDepth); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      credit_q <= credit_d;
      occ_q    <= occ_d;
      mark_q   <= mark_d;
      if (push) begin
        mem_q[wptr_q] <= sram_rdata_i;
        wptr_q        <= nxt(wptr_q);
      end
      if (pop) begin
        rptr_q <= nxt(rptr_q);
      end
    end
  end

endmodule

// File: tb/tb_tc_sram_rsp_adapter.sv
// Bench for tc_sram_rsp_adapter: two instances (L=1/D=2, L=3/D=4)
// with behavioural SRAMs, a golden memory and response scoreboards.
module tb_tc_sram_rsp_adapter;

  localparam int LA = 1;
  localparam int DA = 2;
  localparam int LB = 3;
  localparam int DB = 4;
  localparam int TO = 200;

  logic clk;
  logic rst;

  logic        a_req, a_we, a_rready;
  logic [9:0]  a_addr;
  logic [63:0] a_wd;
  logic [7:0]  a_be;
  logic        a_gnt, a_rvalid, a_sreq, a_swe;
  logic [63:0] a_rdata, a_swd, a_srdata;
  logic [9:0]  a_saddr;
  logic [7:0]  a_sbe;

  logic        b_req, b_we, b_rready;
  logic [9:0]  b_addr;
  logic [63:0] b_wd;
  logic [7:0]  b_be;
  logic        b_gnt, b_rvalid, b_sreq, b_swe;
  logic [63:0] b_rdata, b_swd, b_srdata;
  logic [9:0]  b_saddr;
  logic [7:0]  b_sbe;

  logic [63:0] mem_a  [1024] = '{default: '0};
  logic [63:0] mem_b  [1024] = '{default: '0};
  logic [63:0] gold_a [1024] = '{default: '0};
  logic [63:0] gold_b [1024] = '{default: '0};
  logic [63:0] a_pipe [LA];
  logic [63:0] b_pipe [LB];

  logic [63:0] sb_a [$];
  logic [63:0] sb_b [$];

  int n_cmp = 0;
  int n_err = 0;
  int a_pops = 0;
  int b_pops = 0;
  int b_reads = 0;
  bit b_rnd = 0;

  tc_sram_rsp_adapter #(
    .Latency(LA), .RspDepth(DA)
  ) u_a (
    .clk_i(clk), .rst_i(rst),
    .req_i(a_req), .gnt_o(a_gnt), .we_i(a_we),
    .addr_i(a_addr), .wdata_i(a_wd), .be_i(a_be),
    .rvalid_o(a_rvalid), .rready_i(a_rready),
    .rdata_o(a_rdata),
    .sram_req_o(a_sreq), .sram_we_o(a_swe),
    .sram_addr_o(a_saddr), .sram_wdata_o(a_swd),
    .sram_be_o(a_sbe), .sram_rdata_i(a_srdata)
  );

  tc_sram_rsp_adapter #(
    .Latency(LB), .RspDepth(DB)
  ) u_b (
    .clk_i(clk), .rst_i(rst),
    .req_i(b_req), .gnt_o(b_gnt), .we_i(b_we),
    .addr_i(b_addr), .wdata_i(b_wd), .be_i(b_be),
    .rvalid_o(b_rvalid), .rready_i(b_rready),
    .rdata_o(b_rdata),
    .sram_req_o(b_sreq), .sram_we_o(b_swe),
    .sram_addr_o(b_saddr), .sram_wdata_o(b_swd),
    .sram_be_o(b_sbe), .sram_rdata_i(b_srdata)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  function automatic logic [63:0] merge(
    input logic [63:0] old, input logic [63:0] wd,
    input logic [7:0] be
  );
    logic [63:0] r;
    r = old;
    for (int k = 0; k < 8; k++)
      if (be[k]) r[8*k +: 8] = wd[8*k +: 8];
    return r;
  endfunction

  // Behavioural SRAMs: read data valid L cycles after the request.
  always @(posedge clk) begin
    for (int i = LA - 1; i > 0; i--) a_pipe[i] <= a_pipe[i-1];
    if (a_sreq && !a_swe) a_pipe[0] <= mem_a[a_saddr];
    if (a_sreq && a_swe) mem_a[a_saddr] <= merge(mem_a[a_saddr], a_swd, a_sbe);
  end
  assign a_srdata = a_pipe[LA-1];

  always @(posedge clk) begin
    for (int i = LB - 1; i > 0; i--) b_pipe[i] <= b_pipe[i-1];
    if (b_sreq && !b_swe) b_pipe[0] <= mem_b[b_saddr];
    if (b_sreq && b_swe) mem_b[b_saddr] <= merge(mem_b[b_saddr], b_swd, b_sbe);
  end
  assign b_srdata = b_pipe[LB-1];

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Scoreboards: expectations pushed at grant, popped at response.
  always @(negedge clk) begin
    if (rst) begin
      sb_a.delete();
    end else begin
      if (a_rvalid && a_rready) begin
        a_pops++;
        if (sb_a.size() == 0) chk("a_unexpected_rsp", 64'(a_rvalid), 64'd0);
        else chk("a_rsp_data", a_rdata, sb_a.pop_front());
      end
      if (a_req && a_gnt) begin
        if (a_we) gold_a[a_addr] = merge(gold_a[a_addr], a_wd, a_be);
        else sb_a.push_back(gold_a[a_addr]);
      end
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      sb_b.delete();
    end else begin
      if (b_rvalid && b_rready) begin
        b_pops++;
        if (sb_b.size() == 0) chk("b_unexpected_rsp", 64'(b_rvalid), 64'd0);
        else chk("b_rsp_data", b_rdata, sb_b.pop_front());
      end
      if (b_req && b_gnt) begin
        if (b_we) gold_b[b_addr] = merge(gold_b[b_addr], b_wd, b_be);
        else begin
          sb_b.push_back(gold_b[b_addr]);
          b_reads++;
        end
      end
    end
  end

  task automatic a_do(input logic we, input int addr,
                      input logic [63:0] wd, input logic [7:0] be,
                      output int waits);
    logic g;
    a_req = 1; a_we = we; a_addr = 10'(addr); a_wd = wd; a_be = be;
    waits = 0;
    g = 0;
    while (1) begin
      @(negedge clk);
      g = a_gnt;
      if (g || waits >= TO) break;
      waits++;
      @(posedge clk); #1;
    end
    chk("a_granted", 64'(g), 64'd1);
    @(posedge clk); #1;
    a_req = 0;
  endtask

  task automatic b_do(input logic we, input int addr,
                      input logic [63:0] wd, input logic [7:0] be,
                      output int waits);
    logic g;
    b_req = 1; b_we = we; b_addr = 10'(addr); b_wd = wd; b_be = be;
    if (b_rnd) b_rready = 1'($urandom_range(0, 1));
    waits = 0;
    g = 0;
    while (1) begin
      @(negedge clk);
      g = b_gnt;
      if (g || waits >= TO) break;
      waits++;
      @(posedge clk); #1;
      if (b_rnd) b_rready = 1'($urandom_range(0, 1));
    end
    chk("b_granted", 64'(g), 64'd1);
    @(posedge clk); #1;
    b_req = 0;
  endtask

  task automatic a_drain();
    a_rready = 1;
    repeat (TO) begin
      @(negedge clk);
      if (sb_a.size() == 0 && !a_rvalid) break;
    end
    @(posedge clk); #1;
    chk("a_drain_empty", 64'(sb_a.size()), 64'd0);
  endtask

  task automatic a_wait_grant();
    logic g;
    g = 0;
    repeat (20) begin
      @(negedge clk);
      g = a_gnt;
      @(posedge clk); #1;
      if (g) break;
    end
    chk("a_late_grant", 64'(g), 64'd1);
    a_req = 0;
  endtask

  initial begin
    int w;
    int p0;
    rst = 1;
    a_req = 1; a_we = 0; a_addr = '0; a_wd = '0; a_be = '0; a_rready = 0;
    b_req = 0; b_we = 0; b_addr = '0; b_wd = '0; b_be = '0; b_rready = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_rvalid", 64'(a_rvalid), 64'd0);
    chk("rst_rdata", a_rdata, 64'd0);
    chk("rst_gnt", 64'(a_gnt), 64'd0);
    chk("rst_sram_req", 64'(a_sreq), 64'd0);
    chk("rst_b_rvalid", 64'(b_rvalid), 64'd0);
    @(posedge clk); #1;
    rst = 0; a_req = 0; a_rready = 1; b_rready = 1;
    @(negedge clk);
    chk("post_rst_rvalid", 64'(a_rvalid), 64'd0);
    @(posedge clk); #1;

    // Write then read with exact latency check.
    a_do(1, 'h10, 64'hDEADBEEF_01234567, 8'hFF, w);
    chk("t1_wr_wait", 64'(w), 64'd0);
    a_do(0, 'h10, '0, '0, w);
    chk("t1_rd_wait", 64'(w), 64'd0);
    @(negedge clk);
    chk("t1_rvalid_early", 64'(a_rvalid), 64'd0);
    @(negedge clk);
    chk("t1_rvalid", 64'(a_rvalid), 64'd1);
    chk("t1_rdata", a_rdata, 64'hDEADBEEF_01234567);
    @(posedge clk); #1;

    // Partial byte enables over zeroed memory.
    a_do(1, 3, '1, 8'h0F, w);
    a_do(0, 3, '0, '0, w);
    repeat (10) begin
      @(negedge clk);
      if (a_rvalid) break;
    end
    chk("t2_rvalid", 64'(a_rvalid), 64'd1);
    chk("t2_rdata", a_rdata, 64'h00000000_FFFFFFFF);
    @(posedge clk); #1;
    a_drain();

    // Back-pressure: third read blocked until a pop frees a credit.
    a_do(1, 1, 64'hA1A1_0000_0000_0001, 8'hFF, w);
    a_do(1, 2, 64'hB2B2_0000_0000_0002, 8'hFF, w);
    a_do(1, 3, 64'hC3C3_0000_0000_0003, 8'hFF, w);
    a_rready = 0;
    p0 = a_pops;
    a_do(0, 1, '0, '0, w);
    a_do(0, 2, '0, '0, w);
    a_req = 1; a_we = 0; a_addr = 10'd3;
    repeat (3) begin
      @(negedge clk);
      chk("bp_gnt_blocked", 64'(a_gnt), 64'd0);
      chk("bp_rvalid_hold", 64'(a_rvalid), 64'd1);
      chk("bp_rdata_hold", a_rdata, 64'hA1A1_0000_0000_0001);
      @(posedge clk); #1;
    end
    a_rready = 1;
    a_wait_grant();
    a_drain();
    chk("bp_pop_count", 64'(a_pops - p0), 64'd3);

    // Streaming reads: concurrent push/pop and pointer wrap.
    for (int i = 4; i < 12; i++)
      a_do(1, i, {16'hC0DE, 16'(i), 32'(i * 7)}, 8'hFF, w);
    p0 = a_pops;
    for (int i = 0; i < 12; i++) a_do(0, i, '0, '0, w);
    a_drain();
    chk("stream_pop_count", 64'(a_pops - p0), 64'd12);

    // Reset with reads in flight.
    a_rready = 0;
    a_do(0, 1, '0, '0, w);
    a_do(0, 2, '0, '0, w);
    rst = 1; a_req = 1; a_we = 0; a_addr = 10'd5;
    @(negedge clk);
    chk("mid_rst_gnt", 64'(a_gnt), 64'd0);
    chk("mid_rst_sram_req", 64'(a_sreq), 64'd0);
    chk("mid_rst_rvalid", 64'(a_rvalid), 64'd0);
    @(posedge clk); #1;
    rst = 0; a_req = 0;
    repeat (4) begin
      @(negedge clk);
      chk("after_rst_rvalid", 64'(a_rvalid), 64'd0);
    end
    @(posedge clk); #1;
    p0 = a_pops;
    a_do(0, 6, '0, '0, w);
    chk("after_rst_wait0", 64'(w), 64'd0);
    a_do(0, 7, '0, '0, w);
    chk("after_rst_wait1", 64'(w), 64'd0);
    a_req = 1; a_we = 0; a_addr = 10'd8;
    @(negedge clk);
    chk("after_rst_credit_full", 64'(a_gnt), 64'd0);
    @(posedge clk); #1;
    a_rready = 1;
    a_wait_grant();
    a_drain();
    chk("after_rst_pops", 64'(a_pops - p0), 64'd3);

    // Random traffic on the L=3/D=4 instance.
    b_rnd = 1;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 2) == 0)
        b_do(1, int'($urandom_range(0, 15)), {$urandom, $urandom},
             8'($urandom), w);
      else
        b_do(0, int'($urandom_range(0, 15)), '0, '0, w);
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
        b_rready = 1'($urandom_range(0, 1));
      end
    end
    b_rnd = 0;
    b_rready = 1;
    repeat (TO) begin
      @(negedge clk);
      if (sb_b.size() == 0 && !b_rvalid) break;
    end
    @(posedge clk); #1;
    chk("b_drain_empty", 64'(sb_b.size()), 64'd0);
    chk("b_pops_vs_reads", 64'(b_pops), 64'(b_reads));

`ifdef TC_SRAM_RSP_CREDIT_BYPASS_EN
    for (int i = 0; i < 20; i++) begin
      b_do(0, i, '0, '0, w);
      chk("bypass_no_stall", 64'(w), 64'd0);
    end
    repeat (TO) begin
      @(negedge clk);
      if (sb_b.size() == 0 && !b_rvalid) break;
    end
    @(posedge clk); #1;
    chk("bypass_drain", 64'(sb_b.size()), 64'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
